// File: rtl/pipeline_fork_buffered.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_fork_buffered
// Purpose  : Registered ready/valid fork with a per-word destination mask.
//            Each selected output completes its handshake independently.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_fork_buffered #(
   parameter int WORD_WIDTH   = 8,
   parameter int OUTPUT_COUNT = 2,
   parameter int TOTAL_WIDTH  = WORD_WIDTH * OUTPUT_COUNT
) (
   input  logic                    clock,
   input  logic                    clear,
   input  logic                    input_valid,
   output logic                    input_ready,
   input  logic [WORD_WIDTH-1:0]   input_data,
   input  logic [OUTPUT_COUNT-1:0] input_mask,
   output logic [OUTPUT_COUNT-1:0] output_valid,
   input  logic [OUTPUT_COUNT-1:0] output_ready,
   output logic [TOTAL_WIDTH-1:0]  output_data
);

   logic [OUTPUT_COUNT-1:0] r_pending;
   logic [WORD_WIDTH-1:0]   r_held;
   logic [OUTPUT_COUNT-1:0] w_done;
   logic [OUTPUT_COUNT-1:0] w_stalled;
   logic                    w_accept;

   assign w_done      = r_pending & output_ready;
   assign w_stalled   = r_pending & ~output_ready;
   // Ready only depends on output_ready and local state, never on input_valid.
   assign input_ready = ~clear & (w_stalled == '0);
   assign w_accept    = input_valid & input_ready;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_pending <= '0;
         r_held    <= '0;
      end else if (w_accept) begin
         r_pending <= input_mask;
         r_held    <= input_data;
      end else begin
         r_pending <= r_pending & ~w_done;
      end
   end

   assign output_valid = r_pending;

   generate
      for (genvar g = 0; g < OUTPUT_COUNT; g++) begin : g_slice
         assign output_data[g*WORD_WIDTH +: WORD_WIDTH] = r_held;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipeline_fork_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_fork_buffered
// Purpose  : Directed and randomised checks against a per-output queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_fork_buffered;

   logic       clock = 1'b0;
   logic       clear;
   logic       input_valid;
   logic       input_ready;
   logic [7:0] input_data;
   logic [1:0] input_mask;
   logic [1:0] output_valid;
   logic [1:0] output_ready;
   logic [15:0] output_data;

   logic       v3;
   logic       rdy3;
   logic [7:0] d3;
   logic [2:0] m3;
   logic [2:0] ov3;
   logic [2:0] or3;
   logic [23:0] od3;

   int vectors    = 0;
   int miscompares = 0;

   // Model: one queue of expected words per output.
   logic [7:0] q [2][$];
   logic       exp_ready;
   logic [1:0] prev_v;
   logic [1:0] prev_r;
   logic [7:0] prev_d [2];

   always #5 clock = ~clock;

   pipeline_fork_buffered #(.WORD_WIDTH(8), .OUTPUT_COUNT(2)) dut (
      .clock        (clock),
      .clear        (clear),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .input_mask   (input_mask),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_data  (output_data)
   );

   pipeline_fork_buffered #(.WORD_WIDTH(8), .OUTPUT_COUNT(3)) dut3 (
      .clock        (clock),
      .clear        (clear),
      .input_valid  (v3),
      .input_ready  (rdy3),
      .input_data   (d3),
      .input_mask   (m3),
      .output_valid (ov3),
      .output_ready (or3),
      .output_data  (od3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) q[i].delete();
      prev_v = '0;
   endtask

   // Drive at the falling edge, then compare DUT against the model.
   task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d,
                        input logic [1:0] r);
      @(negedge clock);
      input_valid  = v;
      input_mask   = m;
      input_data   = d;
      output_ready = r;
      #1;
      exp_ready = !clear;
      for (int i = 0; i < 2; i++) begin
         logic ev;
         ev = (q[i].size() != 0);
         chk($sformatf("valid[%0d]", i), {31'd0, output_valid[i]}, {31'd0, ev});
         if (ev) chk($sformatf("data[%0d]", i), {24'd0, output_data[i*8 +: 8]}, {24'd0, q[i][0]});
         if (ev && !r[i]) exp_ready = 1'b0;
         if (!clear && prev_v[i] && !prev_r[i]) begin
            chk($sformatf("stable_valid[%0d]", i), {31'd0, output_valid[i]}, 32'd1);
            chk($sformatf("stable_data[%0d]", i), {24'd0, output_data[i*8 +: 8]}, {24'd0, prev_d[i]});
         end
      end
      chk("input_ready", {31'd0, input_ready}, {31'd0, exp_ready});
      prev_v = output_valid;
      prev_r = r;
      for (int i = 0; i < 2; i++) prev_d[i] = output_data[i*8 +: 8];
   endtask

   task automatic edge_update();
      @(posedge clock);
      if (clear) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++)
            if (q[i].size() != 0 && output_ready[i]) void'(q[i].pop_front());
         if (input_valid && exp_ready)
            for (int i = 0; i < 2; i++)
               if (input_mask[i]) q[i].push_back(input_data);
      end
   endtask

   initial begin
      clear = 1'b1; input_valid = 0; input_mask = 0; input_data = 0; output_ready = 0;
      v3 = 0; m3 = 0; d3 = 0; or3 = 0;
      model_reset();
      #1;
      chk("reset_valid", {30'd0, output_valid}, 32'd0);
      chk("reset_data", {16'd0, output_data}, 32'd0);
      chk("reset_ready", {31'd0, input_ready}, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      clear = 1'b0;

      // Broadcast at full rate
      drive(1, 2'b11, 8'h11, 2'b11); chk("bc_ready0", {31'd0, input_ready}, 32'd1); edge_update();
      drive(1, 2'b11, 8'h22, 2'b11); chk("bc_data0", {16'd0, output_data}, 32'h1111); edge_update();
      drive(1, 2'b11, 8'h33, 2'b11); chk("bc_data1", {16'd0, output_data}, 32'h2222);
      chk("bc_ready2", {31'd0, input_ready}, 32'd1); edge_update();
      drive(0, 2'b00, 8'h00, 2'b11); chk("bc_data2", {16'd0, output_data}, 32'h3333);
      chk("bc_valid2", {30'd0, output_valid}, 32'd3); edge_update();

      // Skewed completion
      drive(1, 2'b11, 8'hA5, 2'b00); chk("sk_ready0", {31'd0, input_ready}, 32'd1); edge_update();
      drive(0, 2'b00, 8'h00, 2'b01); chk("sk_valid1", {30'd0, output_valid}, 32'd3);
      chk("sk_ready1", {31'd0, input_ready}, 32'd0); edge_update();
      drive(0, 2'b00, 8'h00, 2'b01); chk("sk_valid2", {30'd0, output_valid}, 32'd2);
      chk("sk_ready2", {31'd0, input_ready}, 32'd0); edge_update();
      drive(0, 2'b00, 8'h00, 2'b01); chk("sk_ready3", {31'd0, input_ready}, 32'd0);
      chk("sk_data3", {16'd0, output_data}, 32'hA5A5); edge_update();
      drive(1, 2'b11, 8'h5A, 2'b10); chk("sk_ready4", {31'd0, input_ready}, 32'd1); edge_update();
      drive(0, 2'b00, 8'h00, 2'b11); chk("sk_data5", {16'd0, output_data}, 32'h5A5A);
      chk("sk_valid5", {30'd0, output_valid}, 32'd3); edge_update();

      // Zero mask
      drive(1, 2'b00, 8'h44, 2'b11); chk("zm_ready0", {31'd0, input_ready}, 32'd1); edge_update();
      drive(1, 2'b11, 8'h55, 2'b11); chk("zm_valid1", {30'd0, output_valid}, 32'd0);
      chk("zm_ready1", {31'd0, input_ready}, 32'd1); edge_update();
      drive(0, 2'b00, 8'h00, 2'b11); chk("zm_data2", {16'd0, output_data}, 32'h5555);
      chk("zm_valid2", {30'd0, output_valid}, 32'd3); edge_update();

      // Selective mask on the 3-output instance
      drive(0, 2'b00, 8'h00, 2'b11);
      v3 = 1; m3 = 3'b101; d3 = 8'h7E; or3 = 3'b000;
      edge_update();
      drive(0, 2'b00, 8'h00, 2'b11);
      v3 = 0; #1;
      chk("sel_valid", {29'd0, ov3}, 32'd5);
      chk("sel_slice0", {24'd0, od3[7:0]}, 32'h7E);
      chk("sel_slice2", {24'd0, od3[23:16]}, 32'h7E);
      chk("sel_ready", {31'd0, rdy3}, 32'd0);
      edge_update();
      drive(0, 2'b00, 8'h00, 2'b11);
      chk("sel_hold", {29'd0, ov3}, 32'd5);
      or3 = 3'b111;
      edge_update();
      drive(0, 2'b00, 8'h00, 2'b11);
      chk("sel_done", {29'd0, ov3}, 32'd0);
      edge_update();

      // Clear mid-transfer with both outputs pending
      drive(1, 2'b11, 8'h66, 2'b00); edge_update();
      drive(0, 2'b00, 8'h00, 2'b00); chk("clr_pre", {30'd0, output_valid}, 32'd3);
      clear = 1'b1; #1;
      chk("clr_valid", {30'd0, output_valid}, 32'd0);
      chk("clr_data", {16'd0, output_data}, 32'd0);
      chk("clr_ready", {31'd0, input_ready}, 32'd0);
      edge_update();
      @(negedge clock); clear = 1'b0;
      drive(0, 2'b00, 8'h00, 2'b00); chk("clr_after", {31'd0, input_ready}, 32'd1); edge_update();

      // Randomised traffic and backpressure
      for (int n = 0; n < 10000; n++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 2'($urandom));
         edge_update();
      end
      drive(0, 2'b00, 8'h00, 2'b11); edge_update();
      drive(0, 2'b00, 8'h00, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_fork_buffered.md
# pipeline_fork_buffered

Registered, selectively-masked successor to the lazy pipeline fork. It accepts one ready/valid word plus a per-output destination mask and registers both. It then presents the word to every selected output, and each output completes its handshake independently. A new input word is accepted only once every selected output has taken the current word, so no output ever misses or duplicates a word. Use it wherever a fork must not pass a combinational valid path from input to outputs.

## Interface

Parameters:
- WORD_WIDTH, default 8: data word width in bits (≥1).
- OUTPUT_COUNT, default 2: number of output channels (≥1).
- TOTAL_WIDTH, default WORD_WIDTH*OUTPUT_COUNT: derived concatenated output width; never set at instantiation.

Ports:
- clock, input, 1: single clock; all state changes on its rising edge.
- clear, input, 1: reset, asynchronous and active-high.
- input_valid, input, 1: upstream word valid.
- input_ready, output, 1: upstream word accepted this cycle when high with input_valid.
- input_data, input, WORD_WIDTH: upstream word.
- input_mask, input, OUTPUT_COUNT: bit i high means output i receives this word; sampled with input_data.
- output_valid, output, OUTPUT_COUNT: per-output valid; registered.
- output_ready, input, OUTPUT_COUNT: per-output ready.
- output_data, output, TOTAL_WIDTH: registered word replicated to every slice; slice i is bits [i*WORD_WIDTH +: WORD_WIDTH].

## Operation

- State:
  - pending[OUTPUT_COUNT]: one bit per output.
  - held[WORD_WIDTH]: one shared data register.
- output_valid = pending.
- output_data = {OUTPUT_COUNT{held}}.
- done[i] = pending[i] & output_ready[i]. This is output i completing its handshake this cycle.
- input_ready = ~clear & ((pending & ~output_ready) == 0). It is high when nothing is pending or every pending output completes this cycle.
- accept = input_valid & input_ready.
- On accept: held <= input_data and pending <= input_mask.
- Without accept: pending[i] <= pending[i] & ~done[i], and held is unchanged.
- Simultaneous completion and accept: the new mask wins. pending[i] ends at input_mask[i], even if done[i] was high.
- Zero mask: the word is accepted and discarded. pending stays 0, no output_valid is raised, and input_ready stays high the next cycle.
- held changes only on accept. output_data is stable for as long as any pending bit is set.
- Once raised, output_valid[i] stays high until output i completes, independent of other outputs and of input_valid.
- Deasserting output_ready[i] never changes output_valid or output_data.
- Combinational paths:
  - output_ready → input_ready only.
  - No path from input_valid or input_data to any output.

## Timing

- Latency: a word accepted at edge N appears on output_valid and output_data immediately after edge N, i.e. one cycle.
- Throughput: one word per cycle when all selected outputs hold ready high.
- Output order: each output receives words in input order, with no gaps and no repeats. Outputs may complete in different cycles.
- Reset (clear high, at any time including mid-transaction):
  - pending = 0, held = 0, so output_valid = 0 and output_data = 0 immediately, without waiting for a clock edge.
  - input_ready = 0 while clear is high.
  - The word in flight is discarded.
- After clear deasserts: input_ready = 1 in the first cycle.
- Single output (OUTPUT_COUNT = 1): the block degenerates to a one-entry pipeline register with full throughput.

## Test plan

- Reset: assert clear mid-transfer with pending = 2'b11 → output_valid = 0, output_data = 0 and input_ready = 0 with no clock edge. After release, input_ready = 1.
- Broadcast at full rate: OUTPUT_COUNT = 2, WORD_WIDTH = 8, all ready high, send 0x11, 0x22, 0x33 with mask 2'b11 on consecutive cycles → each output sees 0x11, 0x22, 0x33 on consecutive cycles, one cycle after each input, and input_ready stays 1 throughout.
- Skewed completion: send 0xA5 with mask 2'b11. Hold output_ready = 2'b01 for 3 cycles, then 2'b10.
  - Output 0 completes in cycle 1.
  - Output 1 completes in cycle 4.
  - input_ready is 0 in cycles 1–3 and 1 in cycle 4; a word 0x5A offered in cycle 4 is accepted in that same cycle.
- Selective mask: OUTPUT_COUNT = 3, send 0x7E with mask 3'b101 → output_valid = 3'b101, output 1 never asserts valid, and output_data slices 0 and 2 read 0x7E.
- Zero mask: send 0x44 with mask 0 → input_ready = 1, accepted, and output_valid stays 0. The next word 0x55 with mask 2'b11 appears on both outputs.
- Randomised backpressure: random input_valid, mask and output_ready over 10,000 cycles → a scoreboard confirms each output receives exactly its masked words in order. It also confirms output_valid and output_data are stable whenever valid is high and ready is low.
